mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from shared constants.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 EX_MEM_valid  input  1  EX holds a finished instruction.
REQ-005 EX_rf_bus  input  39  {res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}; the flag bits are already valid-qualified by EX.
REQ-006 EX_pc  input  32  PC of the EX instruction.
REQ-007 MEM_allowin  output  1  MEM accepts a new instruction this cycle.
REQ-008 data_sram_rdata  input  32  load data, meaningful only when data_sram_data_ok=1.
REQ-009 data_sram_data_ok  input  1  single-cycle load-response pulse, at most one per load.
REQ-010 WB_allowin  input  1  WB accepts an instruction this cycle.
REQ-011 MEM_WB_valid  output  1  MEM offers a completed instruction to WB.
REQ-012 MEM_WB_bus  output  70  {rf_we, rf_waddr[4:0], rf_wdata[31:0], pc[31:0]}.
REQ-013 MEM_rf_bus  output  39  forwarding/hazard bus {res_from_mem&valid, rf_we&valid, rf_waddr, rf_wdata}.

Function
REQ-014 Capture: when EX_MEM_valid & MEM_allowin, the block SHALL register EX_rf_bus and EX_pc; the registers SHALL otherwise hold.
REQ-015 MEM_valid SHALL load EX_MEM_valid whenever MEM_allowin=1 and SHALL hold otherwise.
REQ-016 ready_go SHALL be ~res_from_mem | data_sram_data_ok | buf_valid.
REQ-017 MEM_allowin SHALL be ~MEM_valid | (ready_go & WB_allowin), evaluated combinationally.
REQ-018 MEM_WB_valid SHALL be MEM_valid & ready_go.
REQ-019 rf_wdata SHALL be alu_result for non-loads; for loads it SHALL be buf_data if buf_valid, else data_sram_rdata.
REQ-020 The state machine SHALL have the states IDLE (MEM_valid=0), WAIT (load without data), and DONE (result available, WB stalled).
REQ-021 FSM transitions: IDLE->WAIT on capture of a load; IDLE->DONE on capture of a non-load; WAIT->DONE on data_ok while WB_allowin=0.
REQ-022 FSM exits: WAIT or DONE->IDLE, WAIT, or DONE on departure, according to the next capture; the FSM SHALL stay in WAIT until data_ok.
REQ-023 Response buffer: on data_ok in state WAIT with WB_allowin=0, the block SHALL set buf_valid and latch buf_data=data_sram_rdata.
REQ-024 buf_valid SHALL clear on departure (MEM_WB_valid & WB_allowin), including when a new instruction is captured in the same cycle.
REQ-025 A load whose data_ok coincides with WB_allowin=1 SHALL depart in that same cycle with zero added latency and no buffering.
REQ-026 A non-load SHALL spend exactly one cycle in MEM when WB_allowin=1, giving back-to-back throughput of one per cycle.
REQ-027 data_ok arriving in IDLE or DONE SHALL be ignored and SHALL NOT alter state; the bench flags it as a protocol error.
REQ-028 MEM_rf_bus SHALL reflect MEM_valid in the same cycle; rf_wdata on it is valid only when ready_go=1.

Reset
REQ-029 While reset=1: MEM_valid=0, FSM=IDLE, buf_valid=0, buf_data=0, all bus registers=0.
REQ-030 Outputs during reset SHALL be MEM_allowin=1, MEM_WB_valid=0, MEM_WB_bus=0, MEM_rf_bus=0.
REQ-031 Reset asserted mid-load SHALL discard the instruction and any buffered data; a data_ok arriving after reset SHALL be ignored.

Structure
REQ-032 The shared header SHALL define the bus widths EX_RF_LEN=39, MEM_WB_LEN=70, MEM_RF_LEN=39 and the FSM state encodings.
REQ-033 The response buffer (buf_valid/buf_data with capture and clear) SHALL be a single sub-module named mem_rdata_buf.
REQ-034 No other hierarchy SHALL be used.

Verification
REQ-035 Non-load: add with waddr=5, alu_result=0x1234 and WB_allowin=1 -> next cycle MEM_WB_valid=1 and bus={1,5,0x1234,pc}.
REQ-036 Load with data_ok two cycles after capture, rdata=0xDEADBEEF -> MEM_allowin=0 and MEM_WB_valid=0 for 2 cycles, then departure with wdata=0xDEADBEEF.
REQ-037 Load with data_ok while WB_allowin=0 for 3 cycles, with rdata changing to 0x0 afterward -> buffered wdata remains 0xDEADBEEF and departs when WB_allowin rises.
REQ-038 Four back-to-back non-loads with WB_allowin=1 -> four consecutive MEM_WB_valid pulses and MEM_allowin held at 1.
REQ-039 Reset asserted in WAIT, then data_ok one cycle after release -> MEM_WB_valid stays 0 and FSM=IDLE.
REQ-040 Departure with a simultaneous new load capture -> buf_valid=0 next cycle and FSM=WAIT.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM encoding and the EX->MEM bus layout for the memory stage.
package mem_stage_pkg;
  localparam int EX_RF_LEN  = 39;
  localparam int MEM_WB_LEN = 70;
  localparam int MEM_RF_LEN = 39;
  localparam int DATA_W     = 32;
  localparam int REG_AW     = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic              res_from_mem;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] alu_result;
  } ex_rf_t;
endpackage

// File: rtl/mem_stage_if.sv
// Pipeline handshake bundle around the memory stage: EX side, data SRAM response, WB side.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                  EX_MEM_valid;
  logic [EX_RF_LEN-1:0]  EX_rf_bus;
  logic [DATA_W-1:0]     EX_pc;
  logic                  MEM_allowin;
  logic [DATA_W-1:0]     data_sram_rdata;
  logic                  data_sram_data_ok;
  logic                  WB_allowin;
  logic                  MEM_WB_valid;
  logic [MEM_WB_LEN-1:0] MEM_WB_bus;
  logic [MEM_RF_LEN-1:0] MEM_rf_bus;

  modport master (
    output EX_MEM_valid, EX_rf_bus, EX_pc, data_sram_rdata, data_sram_data_ok, WB_allowin,
    input  MEM_allowin, MEM_WB_valid, MEM_WB_bus, MEM_rf_bus
  );

  modport slave (
    input  EX_MEM_valid, EX_rf_bus, EX_pc, data_sram_rdata, data_sram_data_ok, WB_allowin,
    output MEM_allowin, MEM_WB_valid, MEM_WB_bus, MEM_rf_bus
  );
endinterface

// File: rtl/mem_rdata_buf.sv
// Holds a load response that arrived while WB was stalled, until the instruction departs.
module mem_rdata_buf
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic              clr,
  input  logic [DATA_W-1:0] rdata,
  output logic              buf_valid,
  output logic [DATA_W-1:0] buf_data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (clr) begin
      buf_valid <= 1'b0;
    end else if (set) begin
      buf_valid <= 1'b1;
      buf_data  <= rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for load data, buffers it across WB stalls, forwards results.
//   state  | meaning
//   IDLE   | no instruction held (MEM_valid=0)
//   WAIT   | load held, response not yet seen
//   DONE   | result available, waiting for WB to accept
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  mem_if
);

  mem_state_e        state_q, state_d;
  ex_rf_t            ex_rf_q;
  logic [DATA_W-1:0] pc_q;
  logic              mem_valid;
  logic              ready_go;
  logic              capture;
  logic              depart;
  logic              buf_set;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] rf_wdata;
  ex_rf_t            ex_in;

  assign ex_in = ex_rf_t'(mem_if.EX_rf_bus);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rf_q <= '0;
      pc_q    <= '0;
    end else if (capture) begin
      ex_rf_q <= ex_in;
      pc_q    <= mem_if.EX_pc;
    end
  end

  always_comb begin
    state_d = state_q;
    if (depart) begin
      if (capture) state_d = ex_in.res_from_mem ? S_WAIT : S_DONE;
      else         state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (capture) state_d = ex_in.res_from_mem ? S_WAIT : S_DONE;
        S_WAIT:  if (mem_if.data_sram_data_ok) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_valid           = (state_q != S_IDLE);
    ready_go            = ~ex_rf_q.res_from_mem | mem_if.data_sram_data_ok | buf_valid;
    mem_if.MEM_allowin  = ~mem_valid | (ready_go & mem_if.WB_allowin);
    mem_if.MEM_WB_valid = mem_valid & ready_go;
    capture             = mem_if.EX_MEM_valid & mem_if.MEM_allowin;
    depart              = mem_if.MEM_WB_valid & mem_if.WB_allowin;
    // Only a response seen in WAIT is meaningful; stray pulses elsewhere are dropped.
    buf_set             = (state_q == S_WAIT) & mem_if.data_sram_data_ok & ~mem_if.WB_allowin;
    if (!ex_rf_q.res_from_mem) rf_wdata = ex_rf_q.alu_result;
    else if (buf_valid)        rf_wdata = buf_data;
    else                       rf_wdata = mem_if.data_sram_rdata;
    mem_if.MEM_WB_bus   = {ex_rf_q.rf_we, ex_rf_q.rf_waddr, rf_wdata, pc_q};
    mem_if.MEM_rf_bus   = {ex_rf_q.res_from_mem & mem_valid, ex_rf_q.rf_we & mem_valid,
                           ex_rf_q.rf_waddr, rf_wdata};
  end

  mem_rdata_buf u_rdata_buf (
    .clk       (clk),
    .reset     (reset),
    .set       (buf_set),
    .clr       (depart),
    .rdata     (mem_if.data_sram_rdata),
    .buf_valid (buf_valid),
    .buf_data  (buf_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus an in-order departure scoreboard.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [MEM_WB_LEN-1:0] exp_q[$];

  mem_stage_if ms_if();

  mem_stage dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (ms_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Departure scoreboard: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    logic [MEM_WB_LEN-1:0] exp_v;
    if (!reset && ms_if.MEM_WB_valid && ms_if.WB_allowin) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected: got bus=%h, required no departure", ms_if.MEM_WB_bus);
      end else begin
        exp_v = exp_q.pop_front();
        if (ms_if.MEM_WB_bus !== exp_v) begin
          failures++;
          $display("FAIL scoreboard_bus: got %h, required %h", ms_if.MEM_WB_bus, exp_v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic ld, input logic [4:0] wa,
                          input logic [31:0] alu, input logic [31:0] pc);
    ms_if.EX_MEM_valid = v;
    ms_if.EX_rf_bus    = {ld, 1'b1, wa, alu};
    ms_if.EX_pc        = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_ex(1'b1, 1'b0, 5'd3, 32'hAAAA_5555, 32'h0000_0100);
    ms_if.WB_allowin        = 1'b1;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (ms_if.MEM_allowin !== 1'b1) begin
      failures++; $display("FAIL reset_allowin: got %b, required 1", ms_if.MEM_allowin);
    end
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b0) begin
      failures++; $display("FAIL reset_wb_valid: got %b, required 0", ms_if.MEM_WB_valid);
    end
    checks++;
    if (ms_if.MEM_WB_bus !== '0) begin
      failures++; $display("FAIL reset_wb_bus: got %h, required 0", ms_if.MEM_WB_bus);
    end
    checks++;
    if (ms_if.MEM_rf_bus !== '0) begin
      failures++; $display("FAIL reset_rf_bus: got %h, required 0", ms_if.MEM_rf_bus);
    end
    tick();
    ms_if.EX_MEM_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nonload();
    drive_ex(1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'h0000_1000);
    exp_q.push_back({1'b1, 5'd5, 32'h0000_1234, 32'h0000_1000});
    @(negedge clk);
    checks++;
    if (ms_if.MEM_allowin !== 1'b1) begin
      failures++; $display("FAIL nonload_allowin: got %b, required 1", ms_if.MEM_allowin);
    end
    tick();
    ms_if.EX_MEM_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b1) begin
      failures++; $display("FAIL nonload_wb_valid: got %b, required 1", ms_if.MEM_WB_valid);
    end
    checks++;
    if (ms_if.MEM_rf_bus !== {1'b0, 1'b1, 5'd5, 32'h0000_1234}) begin
      failures++; $display("FAIL nonload_rf_bus: got %h, required %h", ms_if.MEM_rf_bus,
                           {1'b0, 1'b1, 5'd5, 32'h0000_1234});
    end
    tick();
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b0) begin
      failures++; $display("FAIL nonload_after: got %b, required 0", ms_if.MEM_WB_valid);
    end
    tick();
  endtask

  task automatic test_load_wait();
    drive_ex(1'b1, 1'b1, 5'd7, 32'h0000_0040, 32'h0000_2000);
    exp_q.push_back({1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0000_2000});
    tick();
    ms_if.EX_MEM_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ms_if.MEM_allowin !== 1'b0 || ms_if.MEM_WB_valid !== 1'b0) begin
        failures++;
        $display("FAIL load_wait_stall%0d: got allowin=%b wb_valid=%b, required 0/0",
                 i, ms_if.MEM_allowin, ms_if.MEM_WB_valid);
      end
      tick();
    end
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b1 || ms_if.MEM_allowin !== 1'b1) begin
      failures++;
      $display("FAIL load_wait_depart: got wb_valid=%b allowin=%b, required 1/1",
               ms_if.MEM_WB_valid, ms_if.MEM_allowin);
    end
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_IDLE) begin
      failures++; $display("FAIL load_wait_idle: got state=%0d, required %0d", dut.state_q, S_IDLE);
    end
    tick();
  endtask

  task automatic test_load_buffered();
    drive_ex(1'b1, 1'b1, 5'd9, 32'h0000_0080, 32'h0000_3000);
    exp_q.push_back({1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0000_3000});
    tick();
    ms_if.EX_MEM_valid      = 1'b0;
    ms_if.WB_allowin        = 1'b0;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'hDEAD_BEEF;
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ms_if.MEM_WB_valid !== 1'b1 || ms_if.MEM_rf_bus[31:0] !== 32'hDEAD_BEEF ||
          dut.state_q !== S_DONE) begin
        failures++;
        $display("FAIL buffered_hold%0d: got wb_valid=%b wdata=%h state=%0d, required 1/deadbeef/%0d",
                 i, ms_if.MEM_WB_valid, ms_if.MEM_rf_bus[31:0], dut.state_q, S_DONE);
      end
      tick();
    end
    ms_if.WB_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b1) begin
      failures++; $display("FAIL buffered_depart: got %b, required 1", ms_if.MEM_WB_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b0 || dut.buf_valid !== 1'b0) begin
      failures++;
      $display("FAIL buffered_after: got wb_valid=%b buf_valid=%b, required 0/0",
               ms_if.MEM_WB_valid, dut.buf_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    ms_if.WB_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_ex(1'b1, 1'b0, 5'(i + 1), 32'h0000_0100 + 32'(i), 32'h0000_4000 + 32'(4 * i));
      exp_q.push_back({1'b1, 5'(i + 1), 32'h0000_0100 + 32'(i), 32'h0000_4000 + 32'(4 * i)});
      @(negedge clk);
      checks++;
      if (ms_if.MEM_allowin !== 1'b1 || ms_if.MEM_WB_valid !== (i > 0)) begin
        failures++;
        $display("FAIL b2b_slot%0d: got allowin=%b wb_valid=%b, required 1/%0d",
                 i, ms_if.MEM_allowin, ms_if.MEM_WB_valid, (i > 0));
      end
      tick();
    end
    ms_if.EX_MEM_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_last: got %b, required 1", ms_if.MEM_WB_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain: got %b, required 0", ms_if.MEM_WB_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    drive_ex(1'b1, 1'b1, 5'd11, 32'h0000_00C0, 32'h0000_6000);
    tick();
    ms_if.EX_MEM_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_WAIT) begin
      failures++; $display("FAIL rst_mid_wait: got state=%0d, required %0d", dut.state_q, S_WAIT);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b0 || dut.state_q !== S_IDLE) begin
      failures++;
      $display("FAIL rst_mid_assert: got wb_valid=%b state=%0d, required 0/%0d",
               ms_if.MEM_WB_valid, dut.state_q, S_IDLE);
    end
    tick();
    reset = 1'b0;
    tick();
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h0000_0BAD;
    @(negedge clk);
    checks++;
    if (ms_if.MEM_WB_valid !== 1'b0) begin
      failures++; $display("FAIL rst_late_dataok: got wb_valid=%b, required 0", ms_if.MEM_WB_valid);
    end
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_IDLE || ms_if.MEM_WB_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_post_idle: got state=%0d wb_valid=%b, required %0d/0",
               dut.state_q, ms_if.MEM_WB_valid, S_IDLE);
    end
    tick();
  endtask

  task automatic test_depart_with_capture();
    drive_ex(1'b1, 1'b1, 5'd3, 32'h0000_0010, 32'h0000_5000);
    exp_q.push_back({1'b1, 5'd3, 32'h1111_2222, 32'h0000_5000});
    tick();
    ms_if.EX_MEM_valid      = 1'b0;
    ms_if.WB_allowin        = 1'b0;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h1111_2222;
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    ms_if.WB_allowin        = 1'b1;
    drive_ex(1'b1, 1'b1, 5'd4, 32'h0000_0020, 32'h0000_5004);
    exp_q.push_back({1'b1, 5'd4, 32'h3333_4444, 32'h0000_5004});
    @(negedge clk);
    checks++;
    if (ms_if.MEM_allowin !== 1'b1) begin
      failures++; $display("FAIL dc_allowin: got %b, required 1", ms_if.MEM_allowin);
    end
    tick();
    ms_if.EX_MEM_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.buf_valid !== 1'b0 || dut.state_q !== S_WAIT || ms_if.MEM_WB_valid !== 1'b0) begin
      failures++;
      $display("FAIL dc_next: got buf_valid=%b state=%0d wb_valid=%b, required 0/%0d/0",
               dut.buf_valid, dut.state_q, ms_if.MEM_WB_valid, S_WAIT);
    end
    tick();
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h3333_4444;
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_nonload();
    test_load_wait();
    test_load_buffered();
    test_back_to_back();
    test_reset_mid_load();
    test_depart_with_capture();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
